alu_sequencer: RTL and testbench

- Fixed-latency micro-sequencer that drives the 8-bit ALU's control strobes (c_ain, c_bin, c_alu, c_aout) for one ALU instruction at a time.
- Accepts a decoded request (opcode, source/dest register indices, immediate) over a valid/ready handshake.
- Drives register-file read/write and the shared-bus immediate mux, and signals completion.
- Sits between the instruction decoder and the ALU/register file on the shared 8-bit bus.

---
 rtl/alu_sequencer_pkg.sv | 16 +
 rtl/alu_sequencer_if.sv | 35 +++
 rtl/alu_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU opcode constants for the sequencer slice.
// Optional ILLEGAL_OP_EN build flag lives in alu_sequencer.sv.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_ROW  = 3'd3,
    OP_COL  = 3'd4,
    OP_INCL = 3'd5,
    OP_F    = 3'd6,
    OP_RSV  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Decoder -> sequencer request channel (valid/ready).
// master = decoder side, slave = sequencer side.
interface alu_sequencer_if #(
  parameter int REG_AW = 3
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_opcode;
  logic [REG_AW-1:0] req_ra;
  logic [REG_AW-1:0] req_rb;
  logic [REG_AW-1:0] req_rd;
  logic [7:0]        req_imm;

  modport master (
    output req_valid,
    output req_opcode,
    output req_ra,
    output req_rb,
    output req_rd,
    output req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_opcode,
    input  req_ra,
    input  req_rb,
    input  req_rd,
    input  req_imm,
    output req_ready
  );

endinterface

// File: rtl/alu_sequencer.sv
// Fixed-latency ALU strobe sequencer: IDLE->A->B->EX->WB.
// `define ILLEGAL_OP_EN to trap opcode 7 (err pulse) instead of NOP.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    req,
  output logic [REG_AW-1:0] rf_raddr,
  output logic              rf_re,
  output logic [REG_AW-1:0] rf_waddr,
  output logic              rf_we,
  output logic              imm_sel,
  output logic [7:0]        imm_out,
  output logic              c_ain,
  output logic              c_bin,
  output logic              c_alu,
  output logic              c_aout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_A  = 3'd1,
    S_B  = 3'd2,
    S_EX = 3'd3,
    S_WB = 3'd4
  } state_e;

  state_e            state;
  state_e            state_nx;
  alu_op_e           op_q;
  logic [REG_AW-1:0] ra_q;
  logic [REG_AW-1:0] rb_q;
  logic [REG_AW-1:0] rd_q;
  logic [7:0]        imm_q;
  logic              hs;

  assign req.req_ready = (state == IDLE) && !reset;
  assign hs            = req.req_valid && req.req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_ADD;
      ra_q  <= '0;
      rb_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        op_q  <= alu_op_e'(req.req_opcode);
        ra_q  <= req.req_ra;
        rb_q  <= req.req_rb;
        rd_q  <= req.req_rd;
        imm_q <= req.req_imm;
      end
    end
  end

  always_comb begin
    state_nx = state;
    rf_raddr = '0;
    rf_re    = 1'b0;
    rf_waddr = '0;
    rf_we    = 1'b0;
    imm_sel  = 1'b0;
    imm_out  = '0;
    c_ain    = 1'b0;
    c_bin    = 1'b0;
    c_alu    = 1'b0;
    c_aout   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (hs) begin
`ifdef ILLEGAL_OP_EN
          if (alu_op_e'(req.req_opcode) == OP_RSV)
            state_nx = S_WB;
          else
            state_nx = S_A;
`else
          state_nx = S_A;
`endif
        end
      end
      S_A: begin
        rf_raddr = ra_q;
        rf_re    = 1'b1;
        c_ain    = 1'b1;
        state_nx = S_B;
      end
      S_B: begin
        // ADDI sources operand b from the immediate driver
        if (op_q == OP_ADDI) begin
          imm_sel = 1'b1;
          imm_out = imm_q;
        end else begin
          rf_raddr = rb_q;
          rf_re    = 1'b1;
        end
        c_bin    = 1'b1;
        state_nx = S_EX;
      end
      S_EX: begin
        c_alu    = (op_q != OP_RSV);
        state_nx = S_WB;
      end
      S_WB: begin
        done = 1'b1;
        if (op_q == OP_RSV) begin
`ifdef ILLEGAL_OP_EN
          err = 1'b1;
`endif
        end else if (op_q != OP_F) begin
          c_aout   = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = rd_q;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
// Build with +define+ILLEGAL_OP_EN to cover the trap variant.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] rf_raddr;
  logic       rf_re;
  logic [2:0] rf_waddr;
  logic       rf_we;
  logic       imm_sel;
  logic [7:0] imm_out;
  logic       c_ain, c_bin, c_alu, c_aout;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  alu_sequencer_if #(.REG_AW(3)) q ();

  alu_sequencer #(.REG_AW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (q),
    .rf_raddr (rf_raddr),
    .rf_re    (rf_re),
    .rf_waddr (rf_waddr),
    .rf_we    (rf_we),
    .imm_sel  (imm_sel),
    .imm_out  (imm_out),
    .c_ain    (c_ain),
    .c_bin    (c_bin),
    .c_alu    (c_alu),
    .c_aout   (c_aout),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] pk(
    input logic [3:0] s, input logic re, input logic [2:0] ra,
    input logic we, input logic [2:0] wa, input logic is,
    input logic [7:0] im, input logic b, input logic d,
    input logic e);
    return {8'h0, s, re, ra, we, wa, is, im, b, d, e};
  endfunction

  function automatic logic [31:0] obs();
    return pk({c_ain, c_bin, c_alu, c_aout}, rf_re, rf_raddr,
              rf_we, rf_waddr, imm_sel, imm_out, busy, done, err);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d,
                       input logic [7:0] im);
    q.req_opcode = op;
    q.req_ra     = a;
    q.req_rb     = b;
    q.req_rd     = d;
    q.req_imm    = im;
    q.req_valid  = 1'b1;
    chk("ready_at_issue", 32'(q.req_ready), 32'd1);
    step();
    q.req_valid  = 1'b0;
    q.req_opcode = ~op;
    q.req_ra     = ~a;
    q.req_rb     = ~b;
    q.req_rd     = ~d;
    q.req_imm    = ~im;
  endtask

  initial begin
    logic hs;
    int   n_hs;
    reset        = 1'b1;
    q.req_valid  = 1'b0;
    q.req_opcode = '0;
    q.req_ra     = '0;
    q.req_rb     = '0;
    q.req_rd     = '0;
    q.req_imm    = '0;

    step();
    chk("rst_outs", obs(), 32'd0);
    chk("rst_ready", 32'(q.req_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(q.req_ready), 32'd1);
    chk("post_rst_outs", obs(), 32'd0);
    step();

    // ADD r1,r2 -> r3
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
    chk("add_c1", obs(), pk(4'b1000, 1, 3'd1, 0, 0, 0, 0, 1, 0, 0));
    chk("add_c1_rdy", 32'(q.req_ready), 32'd0);
    step();
    chk("add_c2", obs(), pk(4'b0100, 1, 3'd2, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("add_c3", obs(), pk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("add_c4", obs(), pk(4'b0001, 0, 0, 1, 3'd3, 0, 0, 1, 1, 0));
    step();
    chk("add_idle", obs(), 32'd0);

    // ADDI r4 + 0x2A -> r5, rb field ignored
    issue(OP_ADDI, 3'd4, 3'd6, 3'd5, 8'h2A);
    chk("addi_c1", obs(), pk(4'b1000, 1, 3'd4, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("addi_c2", obs(), pk(4'b0100, 0, 0, 0, 0, 1, 8'h2A, 1, 0, 0));
    step();
    chk("addi_c3", obs(), pk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("addi_c4", obs(), pk(4'b0001, 0, 0, 1, 3'd5, 0, 0, 1, 1, 0));
    step();

    // F r0,r7: flag only, no writeback
    issue(OP_F, 3'd0, 3'd7, 3'd2, 8'h00);
    chk("f_c1", obs(), pk(4'b1000, 1, 3'd0, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("f_c2", obs(), pk(4'b0100, 1, 3'd7, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("f_c3", obs(), pk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("f_c4", obs(), pk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step();

    // ROW r6,r5 -> r7: same fixed sequence
    issue(OP_ROW, 3'd6, 3'd5, 3'd7, 8'h00);
    chk("row_c1", obs(), pk(4'b1000, 1, 3'd6, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("row_c2", obs(), pk(4'b0100, 1, 3'd5, 0, 0, 0, 0, 1, 0, 0));
    step();
    step();
    chk("row_c4", obs(), pk(4'b0001, 0, 0, 1, 3'd7, 0, 0, 1, 1, 0));
    step();

    // req_valid held: handshakes at cycles 0 and 5 only
    q.req_opcode = OP_SUB;
    q.req_ra     = 3'd1;
    q.req_rb     = 3'd1;
    q.req_rd     = 3'd1;
    q.req_valid  = 1'b1;
    n_hs = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) q.req_valid = 1'b0;
      hs = q.req_valid && q.req_ready;
      if (hs) n_hs++;
      chk($sformatf("hold_hs%0d", i), 32'(hs),
          32'((i == 0) || (i == 5)));
      chk($sformatf("hold_busy%0d", i), 32'(busy),
          32'(((i >= 1) && (i <= 4)) || ((i >= 6) && (i <= 9))));
      step();
    end
    chk("hold_hs_total", 32'(n_hs), 32'd2);

    // reset during S_EX aborts the op
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
    step();
    step();
    chk("abort_ex", obs(), pk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    reset = 1'b1;
    step();
    chk("abort_outs", obs(), 32'd0);
    chk("abort_ready", 32'(q.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_rel", 32'(q.req_ready), 32'd1);
    chk("abort_idle", obs(), 32'd0);
    step();
    chk("abort_no_wb", obs(), 32'd0);

    // reserved opcode 7
    issue(OP_RSV, 3'd2, 3'd3, 3'd6, 8'h11);
`ifdef ILLEGAL_OP_EN
    chk("rsv_c1", obs(), pk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    step();
    chk("rsv_idle", obs(), 32'd0);
    chk("rsv_ready", 32'(q.req_ready), 32'd1);
`else
    chk("rsv_c1", obs(), pk(4'b1000, 1, 3'd2, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("rsv_c2", obs(), pk(4'b0100, 1, 3'd3, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("rsv_c3", obs(), pk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step();
    chk("rsv_c4", obs(), pk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step();
    chk("rsv_idle", obs(), 32'd0);
    chk("rsv_ready", 32'(q.req_ready), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
